// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types and constants for the multicore memory path.
//   arb_state_t    : mem_arbiter grant state (IDLE, DGRANT, IGRANT)
//   BLOCK_LAST_BIT : word-address bit that marks the second word of a
//                    two-word dcache block
//   WORD_W         : RAM / cache word width
package cpu_types_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } arb_state_t;

   localparam int BLOCK_LAST_BIT = 2;
   localparam int WORD_W         = 32;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: picks one requester out of a request vector.
//   ARB_ROUND_ROBIN_EN defined   : winner is the first requester at or after
//                                  ptr, wrapping around.
//   ARB_ROUND_ROBIN_EN undefined : winner is the lowest-index requester; ptr
//                                  is ignored.
// Ports:
//   req  in  N      request vector
//   ptr  in  IDX_W  rotation pointer
//   idx  out IDX_W  winner index (0 when no request)
//   vld  out 1      at least one request present
module rr_pick #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);

`ifdef ARB_ROUND_ROBIN_EN
   logic [N-1:0]   rot;
   logic [IDX_W:0] sum;

   // Rotate so that bit 0 is the requester at ptr; the lowest set bit of
   // the rotated vector is the offset from ptr to the winner.
   always_comb begin
      rot = N'({req, req} >> ptr);
      sum = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) sum = {1'b0, ptr} + (IDX_W + 1)'(k);
      end
      if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
      idx = sum[IDX_W-1:0];
      vld = |req;
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[k]) idx = IDX_W'(k);
      end
      vld = |req;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port among CPUS icaches and CPUS dcaches.
// One requester owns the port at a time; dcaches beat icaches, and a dcache
// grant is held across its two-word block. Ties are resolved only in IDLE.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin within each class;
// when undefined, the lowest index in each class always wins).
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   dREN/dWEN   in CPUS  dcache read / write request
//   daddr/dstore in CPUS*32 dcache word address / write data
//   iREN        in CPUS  icache read request
//   iaddr       in CPUS*32 icache word address
//   dwait/iwait out CPUS high while the access is not complete
//   dload/iload out CPUS*32 ramload broadcast to every requester
//   ramREN/ramWEN/ramaddr/ramstore out  RAM port driven by the owner
//   ramload in 32, ram_ready in 1       RAM response
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS = 2
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic [CPUS-1:0]        dREN,
   input  logic [CPUS-1:0]        dWEN,
   input  logic [CPUS*WORD_W-1:0] daddr,
   input  logic [CPUS*WORD_W-1:0] dstore,
   input  logic [CPUS-1:0]        iREN,
   input  logic [CPUS*WORD_W-1:0] iaddr,
   output logic [CPUS-1:0]        dwait,
   output logic [CPUS*WORD_W-1:0] dload,
   output logic [CPUS-1:0]        iwait,
   output logic [CPUS*WORD_W-1:0] iload,
   output logic                   ramREN,
   output logic                   ramWEN,
   output logic [WORD_W-1:0]      ramaddr,
   output logic [WORD_W-1:0]      ramstore,
   input  logic [WORD_W-1:0]      ramload,
   input  logic                   ram_ready
);

   localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;

   arb_state_t        state, state_n;
   logic [IDX_W-1:0]  owner, owner_n;
   logic [IDX_W-1:0]  dptr, iptr;
   logic [CPUS-1:0]   dreq;
   logic [IDX_W-1:0]  d_idx, i_idx;
   logic              d_vld, i_vld;
   logic              own_dren, own_dwen, own_iren;
   logic [WORD_W-1:0] own_daddr, own_dstore, own_iaddr;

   assign dreq = dREN | dWEN;

   rr_pick #(.N(CPUS), .IDX_W(IDX_W)) u_dpick (
      .req (dreq),
      .ptr (dptr),
      .idx (d_idx),
      .vld (d_vld)
   );

   rr_pick #(.N(CPUS), .IDX_W(IDX_W)) u_ipick (
      .req (iREN),
      .ptr (iptr),
      .idx (i_idx),
      .vld (i_vld)
   );

   // Owner's request fields; {owner, 5'd0} is owner*32.
   assign own_dren   = dREN[owner];
   assign own_dwen   = dWEN[owner];
   assign own_iren   = iREN[owner];
   assign own_daddr  = WORD_W'(daddr  >> {owner, 5'd0});
   assign own_dstore = WORD_W'(dstore >> {owner, 5'd0});
   assign own_iaddr  = WORD_W'(iaddr  >> {owner, 5'd0});

   // Read data is broadcast; each requester qualifies it with its own wait.
   assign dload = {CPUS{ramload}};
   assign iload = {CPUS{ramload}};

   always_comb begin
      state_n  = state;
      owner_n  = owner;
      dwait    = '1;
      iwait    = '1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state)
         IDLE: begin
            if (d_vld) begin
               state_n = DGRANT;
               owner_n = d_idx;
            end else if (i_vld) begin
               state_n = IGRANT;
               owner_n = i_idx;
            end
         end
         DGRANT: begin
            // A dropped request abandons the block without touching the RAM.
            if (!(own_dren || own_dwen)) begin
               state_n = IDLE;
            end else begin
               // Read+write together is treated as a write.
               ramWEN       = own_dwen;
               ramREN       = own_dren & ~own_dwen;
               ramaddr      = own_daddr;
               ramstore     = own_dstore;
               dwait[owner] = ~ram_ready;
               if (ram_ready && own_daddr[BLOCK_LAST_BIT]) state_n = IDLE;
            end
         end
         IGRANT: begin
            if (!own_iren) begin
               state_n = IDLE;
            end else begin
               ramREN       = 1'b1;
               ramaddr      = own_iaddr;
               iwait[owner] = ~ram_ready;
               if (ram_ready) state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         owner <= '0;
      end else begin
         state <= state_n;
         owner <= owner_n;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] owner_inc;
   assign owner_inc = (owner == IDX_W'(CPUS - 1)) ? '0 : owner + 1'b1;

   // On release, the class that just finished rotates past its owner.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         dptr <= '0;
         iptr <= '0;
      end else if (state_n == IDLE) begin
         if (state == DGRANT) dptr <= owner_inc;
         if (state == IGRANT) iptr <= owner_inc;
      end
   end
`else
   assign dptr = '0;
   assign iptr = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;

   localparam int CPUS = 2;
   localparam int W    = CPUS * 32;

   logic            CLK = 1'b0;
   logic            nRST;
   logic [CPUS-1:0] dREN, dWEN, iREN;
   logic [W-1:0]    daddr, dstore, iaddr;
   logic [CPUS-1:0] dwait, iwait;
   logic [W-1:0]    dload, iload;
   logic            ramREN, ramWEN;
   logic [31:0]     ramaddr, ramstore, ramload;
   logic            ram_ready;

   int total = 0;
   int bad   = 0;

   // Reference model: who holds the port (0 none, 1 dcache, 2 icache),
   // which CPU, and the rotation pointers of each class.
   int m_kind, m_own, m_dptr, m_iptr;

   mem_arbiter #(.CPUS(CPUS)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .dREN      (dREN),
      .dWEN      (dWEN),
      .daddr     (daddr),
      .dstore    (dstore),
      .iREN      (iREN),
      .iaddr     (iaddr),
      .dwait     (dwait),
      .dload     (dload),
      .iwait     (iwait),
      .iload     (iload),
      .ramREN    (ramREN),
      .ramWEN    (ramWEN),
      .ramaddr   (ramaddr),
      .ramstore  (ramstore),
      .ramload   (ramload),
      .ram_ready (ram_ready)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic bitof(input logic [CPUS-1:0] v, input int o);
      logic [CPUS-1:0] t;
      t = v >> o;
      return t[0];
   endfunction

   function automatic logic [31:0] wordof(input logic [W-1:0] v, input int o);
      logic [W-1:0] t;
      t = v >> (32 * o);
      return t[31:0];
   endfunction

   function automatic logic [W-1:0] setword(input logic [W-1:0] v, input int o, input logic [31:0] x);
      logic [W-1:0] m;
      m = W'(32'hFFFF_FFFF) << (32 * o);
      return (v & ~m) | (W'(x) << (32 * o));
   endfunction

   function automatic int pick(input logic [CPUS-1:0] req, input int ptr);
      int c;
      for (int k = 0; k < CPUS; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
         c = (ptr + k) % CPUS;
`else
         c = k;
`endif
         if (bitof(req, c)) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_kind = 0;
      m_own  = 0;
      m_dptr = 0;
      m_iptr = 0;
   endtask

   // Compare all outputs against what the model says the current owner
   // should be doing with the present inputs.
   task automatic check_all();
      logic [CPUS-1:0] edw, eiw;
      logic            eren, ewen;
      logic [31:0]     ea, es;
      int              o;
      edw  = '1;
      eiw  = '1;
      eren = 1'b0;
      ewen = 1'b0;
      ea   = '0;
      es   = '0;
      o    = m_own;
      if (m_kind == 1 && (bitof(dREN, o) || bitof(dWEN, o))) begin
         ewen = bitof(dWEN, o);
         eren = bitof(dREN, o) & ~ewen;
         ea   = wordof(daddr, o);
         es   = wordof(dstore, o);
         if (ram_ready) edw = edw & ~(CPUS'(1) << o);
      end else if (m_kind == 2 && bitof(iREN, o)) begin
         eren = 1'b1;
         ea   = wordof(iaddr, o);
         if (ram_ready) eiw = eiw & ~(CPUS'(1) << o);
      end
      chk("dwait", W'(dwait), W'(edw));
      chk("iwait", W'(iwait), W'(eiw));
      chk("ramREN", W'(ramREN), W'(eren));
      chk("ramWEN", W'(ramWEN), W'(ewen));
      chk("ramaddr", W'(ramaddr), W'(ea));
      chk("ramstore", W'(ramstore), W'(es));
      chk("dload", dload, {CPUS{ramload}});
      chk("iload", iload, {CPUS{ramload}});
   endtask

   task automatic model_step();
      int w;
      int o;
      o = m_own;
      case (m_kind)
         0: begin
            w = pick(dREN | dWEN, m_dptr);
            if (w >= 0) begin
               m_kind = 1;
               m_own  = w;
            end else begin
               w = pick(iREN, m_iptr);
               if (w >= 0) begin
                  m_kind = 2;
                  m_own  = w;
               end
            end
         end
         1: if (!(bitof(dREN, o) || bitof(dWEN, o)) || (ram_ready && wordof(daddr, o)[2])) begin
            m_kind = 0;
            m_dptr = (o + 1) % CPUS;
         end
         2: if (!bitof(iREN, o) || ram_ready) begin
            m_kind = 0;
            m_iptr = (o + 1) % CPUS;
         end
         default: m_kind = 0;
      endcase
   endtask

   task automatic tick_pre();
      @(negedge CLK);
      check_all();
   endtask

   task automatic tick_post();
      model_step();
      @(posedge CLK);
      #1;
      ramload = $urandom;
   endtask

   initial begin
      int          rr_seq[$];
      int          exp_rr[3];
      logic [CPUS-1:0] dw_s;
      logic [31:0] a;

      nRST      = 1'b0;
      dREN      = '0;
      dWEN      = '0;
      iREN      = '0;
      daddr     = '0;
      dstore    = '0;
      iaddr     = '0;
      ram_ready = 1'b1;
      ramload   = 32'hDEAD_BEEF;
      model_reset();

      // Reset state
      #1;
      chk("rst_dwait", W'(dwait), W'({CPUS{1'b1}}));
      chk("rst_iwait", W'(iwait), W'({CPUS{1'b1}}));
      chk("rst_ramREN", W'(ramREN), W'(1'b0));
      chk("rst_ramWEN", W'(ramWEN), W'(1'b0));
      chk("rst_ramaddr", W'(ramaddr), W'(32'h0));
      chk("rst_ramstore", W'(ramstore), W'(32'h0));
      chk("rst_dload", dload, {CPUS{32'hDEAD_BEEF}});
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      // Single dcache fill
      dREN  = 2'b01;
      daddr = setword(daddr, 0, 32'h100);
      tick_pre();
      chk("fill_idle_wait", W'(dwait[0]), W'(1'b1));
      tick_post();
      tick_pre();
      chk("fill_w0_wait", W'(dwait[0]), W'(1'b0));
      chk("fill_w0_addr", W'(ramaddr), W'(32'h100));
      tick_post();
      daddr = setword(daddr, 0, 32'h104);
      tick_pre();
      chk("fill_w1_wait", W'(dwait[0]), W'(1'b0));
      chk("fill_w1_addr", W'(ramaddr), W'(32'h104));
      tick_post();
      dREN = '0;
      tick_pre();
      chk("fill_idle_ren", W'(ramREN), W'(1'b0));
      tick_post();

      // dcache vs icache contention
      dREN  = 2'b10;
      daddr = setword(daddr, 1, 32'h200);
      iREN  = 2'b01;
      iaddr = setword(iaddr, 0, 32'h40);
      tick_pre();
      tick_post();
      tick_pre();
      chk("cont_d_addr", W'(ramaddr), W'(32'h200));
      chk("cont_iwait_w0", W'(iwait[0]), W'(1'b1));
      tick_post();
      daddr = setword(daddr, 1, 32'h204);
      tick_pre();
      chk("cont_iwait_w1", W'(iwait[0]), W'(1'b1));
      tick_post();
      dREN = '0;
      tick_pre();
      chk("cont_idle_gap", W'(ramREN), W'(1'b0));
      tick_post();
      tick_pre();
      chk("cont_i_wait", W'(iwait[0]), W'(1'b0));
      chk("cont_i_addr", W'(ramaddr), W'(32'h40));
      tick_post();
      iREN = '0;
      tick_pre();
      tick_post();

      // Round robin between two continuous dcache writers
      dWEN   = 2'b11;
      daddr  = setword(daddr, 0, 32'h1000);
      daddr  = setword(daddr, 1, 32'h2000);
      dstore = {32'h2222_2222, 32'h1111_1111};
      for (int cyc = 0; cyc < 30 && rr_seq.size() < 3; cyc++) begin
         tick_pre();
         dw_s = dwait;
         for (int i = 0; i < CPUS; i++)
            if (!bitof(dw_s, i) && !ramaddr[2]) rr_seq.push_back(i);
         tick_post();
         for (int i = 0; i < CPUS; i++)
            if (!bitof(dw_s, i)) begin
               a = wordof(daddr, i) ^ 32'h4;
               daddr = setword(daddr, i, a);
            end
      end
`ifdef ARB_ROUND_ROBIN_EN
      exp_rr = '{0, 1, 0};
`else
      exp_rr = '{0, 0, 0};
`endif
      chk("rr_count", W'(rr_seq.size()), W'(3));
      for (int i = 0; i < 3; i++)
         chk("rr_owner", W'(i < rr_seq.size() ? rr_seq[i] : -1), W'(exp_rr[i]));
      dWEN = '0;
      tick_pre();
      tick_post();
      tick_pre();
      tick_post();

      // RAM stall on word 0 of a write
      dWEN      = 2'b01;
      daddr     = setword(daddr, 0, 32'h208);
      dstore    = setword(dstore, 0, 32'h1234_5678);
      ram_ready = 1'b0;
      tick_pre();
      tick_post();
      for (int i = 0; i < 3; i++) begin
         tick_pre();
         chk("stall_wait", W'(dwait[0]), W'(1'b1));
         chk("stall_addr", W'(ramaddr), W'(32'h208));
         chk("stall_store", W'(ramstore), W'(32'h1234_5678));
         tick_post();
      end
      ram_ready = 1'b1;
      tick_pre();
      chk("stall_done", W'(dwait[0]), W'(1'b0));
      tick_post();
      daddr = setword(daddr, 0, 32'h20C);
      tick_pre();
      tick_post();
      dWEN = '0;
      tick_pre();
      tick_post();

      // Early drop after word 0
      dREN  = 2'b01;
      daddr = setword(daddr, 0, 32'h300);
      daddr = setword(daddr, 1, 32'h400);
      tick_pre();
      tick_post();
      dREN = 2'b11;
      tick_pre();
      chk("drop_w0_addr", W'(ramaddr), W'(32'h300));
      tick_post();
      dREN  = 2'b10;
      daddr = setword(daddr, 0, 32'h304);
      tick_pre();
      chk("drop_no_ren", W'(ramREN), W'(1'b0));
      chk("drop_no_addr", W'(ramaddr), W'(32'h0));
      tick_post();
      tick_pre();
      tick_post();
      tick_pre();
      chk("drop_next_addr", W'(ramaddr), W'(32'h400));
      chk("drop_next_wait", W'(dwait[1]), W'(1'b0));
      tick_post();
      daddr = setword(daddr, 1, 32'h404);
      tick_pre();
      tick_post();
      dREN = '0;
      tick_pre();
      tick_post();

      // Reset in the middle of a burst
      dWEN   = 2'b01;
      daddr  = setword(daddr, 0, 32'h500);
      dstore = setword(dstore, 0, 32'hABCD_0001);
      tick_pre();
      tick_post();
      tick_pre();
      chk("rstmid_wen_before", W'(ramWEN), W'(1'b1));
      #2;
      nRST = 1'b0;
      #1;
      chk("rstmid_wen", W'(ramWEN), W'(1'b0));
      chk("rstmid_dwait", W'(dwait), W'({CPUS{1'b1}}));
      chk("rstmid_iwait", W'(iwait), W'({CPUS{1'b1}}));
      chk("rstmid_addr", W'(ramaddr), W'(32'h0));
      model_reset();
      @(posedge CLK);
      #1;
      chk("rstmid_hold", W'(ramWEN), W'(1'b0));
      nRST = 1'b1;
      tick_pre();
      tick_post();
      tick_pre();
      chk("rstmid_restart", W'(ramaddr), W'(32'h500));
      tick_post();
      dWEN = '0;
      tick_pre();
      tick_post();

      // Random traffic against the model
      for (int cyc = 0; cyc < 400; cyc++) begin
         dREN      = CPUS'($urandom) & CPUS'($urandom);
         dWEN      = CPUS'($urandom) & CPUS'($urandom);
         iREN      = CPUS'($urandom);
         ram_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < CPUS; i++) begin
            daddr  = setword(daddr, i, $urandom & 32'h0000_0FFC);
            dstore = setword(dstore, i, $urandom);
            iaddr  = setword(iaddr, i, $urandom & 32'h0000_0FFC);
         end
         tick_pre();
         tick_post();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single RAM port among all instruction and data caches of a multicore build. Each core has an icache (single-word fetches) and a dcache (two-word block fills, block write-backs and halt-time flush writes). The block grants one requester at a time, holds a dcache grant across its two-word burst, and generates the per-requester wait and load signals. It sits between the per-CPU cache_control interface and the RAM model.

## Interface
- CPUS, 2, number of cores; each core owns one icache and one dcache requester
- CLK  in  1  system clock
- nRST  in  1  reset, asynchronous, active-low
- dREN  in  CPUS  dcache read request, per CPU
- dWEN  in  CPUS  dcache write request, per CPU
- daddr  in  CPUS×32  dcache word address
- dstore  in  CPUS×32  dcache write data
- iREN  in  CPUS  icache read request
- iaddr  in  CPUS×32  icache word address
- dwait  out  CPUS  high = dcache access not complete this cycle
- dload  out  CPUS×32  dcache read data; valid when dwait low
- iwait  out  CPUS  high = icache access not complete this cycle
- iload  out  CPUS×32  icache read data; valid when iwait low
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ram_ready  in  1  RAM completes the driven access this cycle

## Operation
- States:
  - IDLE: no grant.
  - DGRANT: a dcache owns the port.
  - IGRANT: an icache owns the port.
- Registers:
  - state
  - owner index
  - dptr: round-robin pointer for dcaches
  - iptr: round-robin pointer for icaches
- Request definitions:
  - A dcache requests when dREN|dWEN.
  - An icache requests when iREN.
- IDLE arbitration:
  - Any dcache request beats every icache request.
  - Among dcaches, the winner is the first requester at or after dptr; icaches use iptr the same way.
  - The winner is registered as owner.
  - The next state is DGRANT or IGRANT.
- DGRANT:
  - RAM driven from owner's dREN, dWEN, daddr, dstore.
  - If dREN and dWEN are both high, treat as a write: ramREN=0.
  - dwait[owner] = !ram_ready.
  - Release on ram_ready with daddr[owner][2]==1 (second word of the block).
  - Otherwise hold the grant for the next word.
- IGRANT:
  - ramREN=1; ramaddr=iaddr[owner].
  - iwait[owner] = !ram_ready.
  - Release on ram_ready (single word).
- Early release: in either grant state, if the owner drops its request, release immediately. RAM enables are driven 0 that cycle.
- On release:
  - Go to IDLE.
  - Set the matching pointer to owner+1 mod CPUS.
- Wait signals: every non-owner wait output is held 1; wait is also 1 in IDLE.
- Load data: dload[i] and iload[i] are all driven with ramload (broadcast); they are meaningful only when the matching wait is low.
- Outputs in IDLE: ramREN, ramWEN, ramaddr, ramstore are all 0.

## Timing
- Reset values:
  - state=IDLE, owner=0, dptr=0, iptr=0
  - all dwait/iwait = 1
  - ramREN = ramWEN = 0
  - ramaddr = ramstore = 0
  - dload/iload = ramload
- Minimum latency, request raised in cycle 0 with ram_ready held high:
  - the grant registers at edge 1;
  - wait drops in cycle 1.
- Full dcache burst:
  - two completions in consecutive grant cycles;
  - release at the edge after word 1;
  - next arbitration in the following IDLE cycle (one idle cycle between grants).
- A requester must hold its address and data stable while its wait is high.
- Simultaneous requests:
  - dcache over icache;
  - round-robin within each class;
  - ties are decided only in IDLE, never mid-grant.
- A starved icache is served once no dcache is requesting.
- Reset asserted mid-grant:
  - outputs return to reset values asynchronously;
  - the partial burst is abandoned.

## Configuration
- ARB_ROUND_ROBIN_EN:
  - Defined: dptr/iptr rotate as above.
  - Undefined: no pointers exist; the lowest-index requester in each class always wins. Dcache-over-icache priority is unchanged.

## Structure
- cpu_types_pkg gains:
  - arb_state_t enum (IDLE, DGRANT, IGRANT);
  - constant BLOCK_LAST_BIT = 2.
- Sub-module rr_pick:
  - inputs: request vector, pointer;
  - outputs: winner index, valid.
  - Instantiated once for dcaches and once for icaches.
  - It contains the only difference between the ARB_ROUND_ROBIN_EN builds.

## Test plan
- Single dcache fill: dREN[0], daddr 0x100, then 0x104; ram_ready=1 -> dwait[0] low in the two grant cycles; ramaddr 0x100 then 0x104; returns to IDLE.
- dcache vs icache contention: dREN[1] and iREN[0] together -> DGRANT owner 1 completes the burst; IGRANT owner 0 follows; iwait[0] stays 1 throughout the burst.
- Round robin: dWEN[0] and dWEN[1] held continuously -> grants alternate 0,1,0; with macro undefined, CPU 0 wins every time.
- RAM stall: ram_ready low for 3 cycles on word 0 of a write at 0x208 -> dwait held 1 and ramaddr/ramstore stable; completes on the 4th cycle.
- Early drop: owner lowers dREN after word 0 (address 0x300) -> release without touching 0x304; the other CPU is granted next.
- Reset mid-burst: nRST low during DGRANT -> ramWEN=0 immediately, all waits 1; after release, arbitration restarts cleanly.
